// File: rtl/ahb_stream_subordinate.sv
// AHB-Lite subordinate front end for the accelerator core.
// Streams bus writes into an input FIFO (core side pops), streams core results through an
// output FIFO (bus side pops), and exposes CTRL/STATUS registers.
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   hsel..hwdata               AHB-Lite address/data phase inputs (hburst accepted, unused)
//   hrdata, hresp, hready      AHB-Lite response
//   acc_in_data/valid/ready    input FIFO head towards the core
//   acc_out_data/valid/ready   core results into the output FIFO
//   acc_start, acc_busy        core start pulse and busy status
module ahb_stream_subordinate #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IN_DEPTH   = 8,
  parameter int unsigned OUT_DEPTH  = 8,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hresp,
  output logic                  hready,
  output logic [DATA_WIDTH-1:0] acc_in_data,
  output logic                  acc_in_valid,
  input  logic                  acc_in_ready,
  input  logic [DATA_WIDTH-1:0] acc_out_data,
  input  logic                  acc_out_valid,
  output logic                  acc_out_ready,
  output logic                  acc_start,
  input  logic                  acc_busy
);

  localparam int unsigned SizeMax = $clog2(DATA_WIDTH / 8);
  localparam int unsigned InPtrW  = $clog2(IN_DEPTH);
  localparam int unsigned InCntW  = InPtrW + 1;
  localparam int unsigned OutPtrW = $clog2(OUT_DEPTH);
  localparam int unsigned OutCntW = OutPtrW + 1;
  localparam int unsigned StallW  = $clog2(WAIT_LIMIT + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StData   = 3'd1;
  localparam logic [2:0] StWaitWr = 3'd2;
  localparam logic [2:0] StWaitRd = 3'd3;
  localparam logic [2:0] StErr1   = 3'd4;
  localparam logic [2:0] StErr2   = 3'd5;

  // Decoded access kind carried from the address phase into the data phase.
  localparam logic [2:0] KindCtrlWr = 3'd0;
  localparam logic [2:0] KindCtrlRd = 3'd1;
  localparam logic [2:0] KindStatus = 3'd2;
  localparam logic [2:0] KindDin    = 3'd3;
  localparam logic [2:0] KindDout   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [2:0]            kind_q;
  logic [2:0]            size_q;
  logic [StallW-1:0]     stall_q, stall_d;
  logic                  start_q, start_d;
  logic                  clear;

  logic [DATA_WIDTH-1:0] in_mem [IN_DEPTH];
  logic [InPtrW-1:0]     in_wr_q, in_rd_q;
  logic [InCntW-1:0]     in_cnt_q;
  logic                  in_push, in_pop, in_full;

  logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [OutPtrW-1:0]    out_wr_q, out_rd_q;
  logic [OutCntW-1:0]    out_cnt_q;
  logic                  out_push, out_pop, out_empty;

  logic [DATA_WIDTH-1:0] rd_word, rd_mask, status_word;
  logic [2:0]            dec_kind;
  logic                  dec_err, is_ctrl, is_status, is_din, is_dout, misaligned, size_bad;

  logic unused_in;
  assign unused_in = ^{hburst, htrans[0]};

  // Address-phase decode
  assign is_ctrl    = (haddr == '0);
  assign is_status  = (haddr == ADDR_WIDTH'(8));
  assign is_din     = (haddr[ADDR_WIDTH-1:8] == (ADDR_WIDTH-8)'(1));
  assign is_dout    = (haddr[ADDR_WIDTH-1:8] == (ADDR_WIDTH-8)'(2));
  assign misaligned = |haddr[SizeMax-1:0];
  assign size_bad   = (hsize > 3'(SizeMax));

  always_comb begin
    dec_kind = KindCtrlRd;
    dec_err  = 1'b1;
    if (is_ctrl) begin
      dec_kind = hwrite ? KindCtrlWr : KindCtrlRd;
      dec_err  = 1'b0;
    end else if (is_status && !hwrite) begin
      dec_kind = KindStatus;
      dec_err  = 1'b0;
    end else if (is_din && hwrite) begin
      dec_kind = KindDin;
      dec_err  = 1'b0;
    end else if (is_dout && !hwrite) begin
      dec_kind = KindDout;
      dec_err  = 1'b0;
    end
    if (misaligned || size_bad) dec_err = 1'b1;
  end

  // FIFO status
  assign in_full       = (in_cnt_q == InCntW'(IN_DEPTH));
  assign acc_in_valid  = (in_cnt_q != '0);
  assign acc_in_data   = in_mem[in_rd_q];
  assign in_pop        = acc_in_valid & acc_in_ready;
  assign out_empty     = (out_cnt_q == '0);
  assign acc_out_ready = (out_cnt_q != OutCntW'(OUT_DEPTH));
  assign out_push      = acc_out_valid & acc_out_ready;

  always_comb begin
    status_word        = '0;
    status_word[0]     = acc_busy;
    status_word[1]     = in_full;
    status_word[2]     = out_empty;
    status_word[11:8]  = 4'(in_cnt_q);
    status_word[19:16] = 4'(out_cnt_q);
  end

  // Data-phase FSM; hready is derived from registered state only, so it can gate acceptance of
  // the next address phase within the same block without forming a loop.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    rd_word = '0;
    in_push = 1'b0;
    out_pop = 1'b0;
    start_d = 1'b0;
    clear   = 1'b0;
    case (state_q)
      StData, StWaitWr, StWaitRd: begin
        case (kind_q)
          KindDin: begin
            if (in_full) hready = 1'b0;
            else         in_push = 1'b1;
          end
          KindDout: begin
            if (out_empty) begin
              hready = 1'b0;
            end else begin
              out_pop = 1'b1;
              rd_word = out_mem[out_rd_q];
            end
          end
          KindStatus: rd_word = status_word;
          KindCtrlWr: begin
            start_d = hwdata[0];
            clear   = hwdata[1];
          end
          default: ; // CTRL bits are self-clearing and read as zero
        endcase
        if (!hready) begin
          if (kind_q == KindDin) begin
            state_d = StWaitWr;
          end else begin
            stall_d = stall_q + StallW'(1);
            state_d = (stall_d >= StallW'(WAIT_LIMIT)) ? StErr1 : StWaitRd;
          end
        end
      end
      StErr1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = StErr2;
      end
      StErr2: hresp = 1'b1;
      default: ;
    endcase
    if (hready) begin
      if (hsel && htrans[1]) begin
        state_d = dec_err ? StErr1 : StData;
        stall_d = '0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Narrow reads return the low bytes only, zero-extended.
  always_comb begin
    case (size_q)
      3'd0:    rd_mask = DATA_WIDTH'(8'hff);
      3'd1:    rd_mask = DATA_WIDTH'(16'hffff);
      3'd2:    rd_mask = DATA_WIDTH'(32'hffff_ffff);
      default: rd_mask = '1;
    endcase
  end

  assign hrdata    = rd_word & rd_mask;
  assign acc_start = start_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      kind_q  <= KindCtrlRd;
      size_q  <= '0;
      stall_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      start_q <= start_d;
      if (hready && hsel && htrans[1]) begin
        kind_q <= dec_kind;
        size_q <= hsize;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_q]   <= hwdata;
    if (out_push) out_mem[out_wr_q] <= acc_out_data;
  end

  // CLEAR overrides any concurrent push or pop on either FIFO.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      in_cnt_q <= '0;
    end else if (clear) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      in_cnt_q <= '0;
    end else begin
      if (in_push) in_wr_q <= in_wr_q + InPtrW'(1);
      if (in_pop)  in_rd_q <= in_rd_q + InPtrW'(1);
      if (in_push && !in_pop)      in_cnt_q <= in_cnt_q + InCntW'(1);
      else if (!in_push && in_pop) in_cnt_q <= in_cnt_q - InCntW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else if (clear) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (out_push) out_wr_q <= out_wr_q + OutPtrW'(1);
      if (out_pop)  out_rd_q <= out_rd_q + OutPtrW'(1);
      if (out_push && !out_pop)      out_cnt_q <= out_cnt_q + OutCntW'(1);
      else if (!out_push && out_pop) out_cnt_q <= out_cnt_q - OutCntW'(1);
    end
  end

endmodule

// File: doc/ahb_stream_subordinate.md
Name: ahb_stream_subordinate

Overview:
Parametrised AHB-Lite subordinate front end for the AI accelerator. It replaces fixed single-register access with buffered streaming:
- Input FIFO carries weights and activations to the core.
- Output FIFO carries results back to the bus.
- Control and status registers manage the core.
- Wait states apply when a buffer is full or empty; two-cycle ERROR responses flag illegal accesses and read timeouts.

Parameters:
ADDR_WIDTH, 10, bus address width (bytes).
DATA_WIDTH, 64, bus and FIFO word width; legal values 32 or 64.
IN_DEPTH, 8, input FIFO entries; power of 2, at least 2.
OUT_DEPTH, 8, output FIFO entries; power of 2, at least 2.
WAIT_LIMIT, 16, maximum stall cycles on a read from an empty output FIFO before an ERROR response.

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- hsel  in  1  subordinate select.
- haddr  in  ADDR_WIDTH  transfer address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  in  3  transfer size, log2 bytes.
- hburst  in  3  burst type; accepted, not used for decode.
- hwrite  in  1  1 = write.
- hwdata  in  DATA_WIDTH  write data (data phase).
- hrdata  out  DATA_WIDTH  read data.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hready  out  1  transfer complete / wait state (low = wait).
- acc_in_data  out  DATA_WIDTH  input FIFO head.
- acc_in_valid  out  1  input FIFO non-empty.
- acc_in_ready  in  1  core pops the input FIFO when valid and ready are both high.
- acc_out_data  in  DATA_WIDTH  result word from the core.
- acc_out_valid  in  1  core offers a result word.
- acc_out_ready  out  1  output FIFO not full.
- acc_start  out  1  one-cycle start pulse.
- acc_busy  in  1  core busy status.

Behaviour:
- Reset (n_rst low, asynchronous):
  - Outputs: hready=1, hresp=0, hrdata=0, acc_start=0.
  - Both FIFOs empty; state IDLE.
  - Reset mid-transfer aborts the transfer without completing it.
- Address phase is captured when hsel & htrans[1] & hready; the data phase follows in the next cycle. IDLE, BUSY, or hsel=0 gives a zero-wait OKAY with no side effects.
- Address map (byte address, word aligned), with N = DATA_WIDTH/8:
  - 0x000 CTRL, R/W. Bit0 START: writing 1 pulses acc_start for exactly one cycle and always reads 0. Bit1 CLEAR: writing 1 empties both FIFOs at the end of that data phase and reads 0.
  - 0x008 STATUS, RO.
    - bit0 acc_busy
    - bit1 input FIFO full
    - bit2 output FIFO empty
    - bits[11:8] input FIFO count
    - bits[19:16] output FIFO count
    - all other bits 0
  - 0x100 to 0x1FF DATA_IN window, WO. Every beat pushes hwdata, so INCR and WRAP bursts stream naturally.
  - 0x200 to 0x2FF DATA_OUT window, RO. Every beat pops one word.
- ERROR conditions:
  - address outside the map;
  - write to STATUS or DATA_OUT;
  - read of DATA_IN;
  - hsize > log2(N);
  - misaligned address.
- ERROR response is two cycles: first cycle hresp=1, hready=0; second cycle hresp=1, hready=1. An erroring transfer has no side effect.
- State machine:
  - IDLE: no pending data phase.
  - DATA: single-cycle OKAY completion; reads return hrdata in the same cycle hready=1.
  - WAIT_WR: input FIFO full at the data phase. Hold hready=0; push hwdata in the first cycle with count < IN_DEPTH, then complete OKAY.
  - WAIT_RD: output FIFO empty. Hold hready=0 and count stall cycles. Return the head and pop on the first non-empty cycle. When the count reaches WAIT_LIMIT, go to ERR1.
  - ERR1 goes to ERR2, then to IDLE or the next data phase.
- Pipelining: a new address phase may be accepted in the cycle hready=1 completes the previous data phase.
- FIFO behaviour:
  - Same-cycle push and pop are allowed in both FIFOs. Count is unchanged; when full, the pop frees the slot only from the next cycle.
  - The core side pops the input FIFO on acc_in_valid & acc_in_ready.
  - The output FIFO pushes on acc_out_valid & acc_out_ready.
  - Pointers wrap modulo depth; count width is clog2(depth)+1.
- CLEAR coinciding with a core push or pop: the clear wins and both FIFOs read empty next cycle.
- Narrow reads return zero-extended register data. Narrow writes to DATA_IN push the full hwdata word.

Test Plan:
- Reset, then read STATUS → hrdata bit2=1, counts 0, hresp=0, hready=1.
- INCR4 write at 0x100 with data 1..4, acc_in_ready=0 → IN count=4; then acc_in_ready=1 → acc_in_data sequence 1,2,3,4.
- IN_DEPTH+1 writes with acc_in_ready=0 → last beat stalls with hready=0; raising acc_in_ready for 1 cycle → stall releases next cycle with OKAY and count stays IN_DEPTH.
- Read 0x200 with output FIFO empty, core pushes 0xDEAD after 5 cycles → hready=0 for 5 cycles, then hrdata=0xDEAD OKAY; with no push → ERROR after WAIT_LIMIT=16 cycles.
- Write 0x3F0 and write STATUS → two-cycle ERROR each, FIFO counts unchanged.
- Write CTRL=1 → acc_start high exactly 1 cycle. Write CTRL=2 with both FIFOs holding 3 words → STATUS counts 0. Assert n_rst low during a WAIT_RD stall → hready=1 immediately.
